// File: rtl/dense_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming dense MAC.
package dense_stream_pkg;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_t;

    // Product width plus headroom for N_IN accumulations.
    function automatic int acc_w_default(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    // Index width that stays legal when a dimension is 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round half toward +inf, arithmetic shift, then clamp to a signed width-bit range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum,
                                                     input int width,
                                                     input int nfrac);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (nfrac > 0)
            r = (sum + (64'sd1 <<< (nfrac - 1))) >>> nfrac;
        else
            r = sum;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/dense_stream_round_sat.sv
// Per-channel bias add, round and saturate; DENSE_STREAM_RELU_EN adds a fused ReLU.
module dense_stream_round_sat
    import dense_stream_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int NFRAC = 7,
    parameter int ACC_W = 35
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] bias,
    output logic [WIDTH-1:0] res
);

    logic signed [63:0] acc_x;
    logic signed [63:0] bias_x;
    logic signed [63:0] sum;
    logic signed [63:0] sat;

    always_comb begin
        acc_x  = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
        bias_x = {{(64-WIDTH){bias[WIDTH-1]}}, bias};
        // Bias is in data format, so align it to the product's 2*NFRAC scale.
        sum    = acc_x + (bias_x <<< NFRAC);
        sat    = sat_round(sum, WIDTH, NFRAC);
`ifdef DENSE_STREAM_RELU_EN
        if (sat < 0)
            sat = '0;
`endif
        res    = WIDTH'(sat);
    end

endmodule

// File: rtl/dense_stream_mac.sv
// Streaming dense layer: one activation per handshake into N_OUT parallel MACs, then bias/round/sat.
// Optional macro DENSE_STREAM_RELU_EN fuses a ReLU into the output stage.
module dense_stream_mac
    import dense_stream_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int NFRAC  = 7,
    parameter int N_IN   = 32,
    parameter int N_OUT  = 5,
    parameter int ACC_W  = acc_w_default(WIDTH, N_IN),
    localparam int ROW_W = idx_w(N_IN),
    localparam int COL_W = idx_w(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic                   cfg_bias,
    input  logic [ROW_W-1:0]       cfg_row,
    input  logic [COL_W-1:0]       cfg_col,
    input  logic [WIDTH-1:0]       cfg_data,
    output logic                   cfg_ready,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data
);

    state_t state, state_nx;
    logic [ROW_W-1:0] count;
    logic in_fire, cfg_fire, last_in;

    logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] w_mem;
    logic [N_OUT-1:0][WIDTH-1:0]           bias_mem;
    logic [N_OUT-1:0][WIDTH-1:0]           res;

    assign in_fire  = in_valid & in_ready;
    assign cfg_fire = cfg_we & cfg_ready;
    assign last_in  = (count == ROW_W'(N_IN - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_ACC: begin
                in_ready  = 1'b1;
                cfg_ready = (count == '0);
                if (in_valid && last_in)
                    state_nx = S_FIN;
            end
            S_FIN: state_nx = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = S_ACC;
            end
            default: state_nx = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ACC;
            count <= '0;
        end else begin
            state <= state_nx;
            if (in_fire)
                count <= last_in ? '0 : count + 1'b1;
        end
    end

    // Coefficient storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (cfg_fire && (32'(cfg_col) < N_OUT)) begin
            if (cfg_bias)
                bias_mem[cfg_col] <= cfg_data;
            else if (32'(cfg_row) < N_IN)
                w_mem[cfg_row][cfg_col] <= cfg_data;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        logic signed [2*WIDTH-1:0] prod;
        logic [ACC_W-1:0]          acc;

        assign prod = $signed(in_data) * $signed(w_mem[count][j]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                acc <= '0;
            else if (state == S_FIN)
                acc <= '0;
            else if (in_fire)
                acc <= acc + ACC_W'(prod);
        end

        dense_stream_round_sat #(
            .WIDTH(WIDTH),
            .NFRAC(NFRAC),
            .ACC_W(ACC_W)
        ) u_rs (
            .acc (acc),
            .bias(bias_mem[j]),
            .res (res[j])
        );
    end

    // Result is captured once in S_FIN and held through S_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_data <= '0;
        else if (state == S_FIN)
            out_data <= res;
    end

endmodule
